// File: rtl/redun_to_binary_serializer_if.sv
// Handshake bundle for redun_to_binary_serializer: redundant vector in, canonical word stream out.
// slave is the serializer's view; master is the upstream producer / downstream consumer view.
interface redun_to_binary_serializer_if #(
  parameter int NUM_ELEMENTS = 66,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16
);

  localparam int CARRY_LEN = DSP_BIT_LEN - WORD_LEN + 1;

  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] i_dat;
  logic                                     i_val;
  logic                                     o_rdy;
  logic [WORD_LEN-1:0]                      o_dat;
  logic                                     o_val;
  logic                                     i_rdy;
  logic                                     o_sop;
  logic                                     o_eop;
  logic [CARRY_LEN-1:0]                     o_carry;

  modport slave (
    input  i_dat, i_val, i_rdy,
    output o_rdy, o_dat, o_val, o_sop, o_eop, o_carry
  );

  modport master (
    output i_dat, i_val, i_rdy,
    input  o_rdy, o_dat, o_val, o_sop, o_eop, o_carry
  );

endinterface

// File: rtl/redun_to_binary_serializer.sv
// Redundant-to-binary serializer: resolves a coefficient vector's carries LSW first and streams canonical words.
// Define REDUN_SER_DBUF_EN to add a second capture buffer so the next vector can queue while one streams.
module redun_to_binary_serializer #(
  parameter int NUM_ELEMENTS = 66,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16
) (
  input logic                         i_clk,
  input logic                         i_rst,
  redun_to_binary_serializer_if.slave bus
);

  localparam int CARRY_LEN = DSP_BIT_LEN - WORD_LEN + 1;
  localparam int VEC_LEN   = NUM_ELEMENTS * DSP_BIT_LEN;
  localparam int IDX_W     = $clog2(NUM_ELEMENTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);
  localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_ELEMENTS);
  localparam logic ONE_ELEMENT = (NUM_ELEMENTS == 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t               state;
  logic [VEC_LEN-1:0]   buf_q;
  logic [CARRY_LEN-1:0] carry_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WORD_LEN-1:0]  dat_q;
  logic                 val_q;
  logic                 sop_q;
  logic                 eop_q;
  logic [CARRY_LEN-1:0] ocarry_q;
  logic                 rdy;
  logic                 accept;
  logic [DSP_BIT_LEN:0] sum;
  logic [WORD_LEN-1:0]  sum_word;
  logic [CARRY_LEN-1:0] sum_carry;

  // buf_q shifts down one coefficient per word, so the element being resolved is always the low slice.
  assign sum       = {1'b0, buf_q[DSP_BIT_LEN-1:0]} + {{WORD_LEN{1'b0}}, carry_q};
  assign sum_word  = sum[WORD_LEN-1:0];
  assign sum_carry = sum[DSP_BIT_LEN:WORD_LEN];

`ifdef REDUN_SER_DBUF_EN
  logic [VEC_LEN-1:0] buf2_q;
  logic               full2_q;
  logic               handoff;

  // handoff only steers registers, so i_rdy never reaches o_rdy combinationally.
  assign rdy     = !i_rst && !full2_q;
  assign handoff = (state == STREAM) && bus.i_rdy && eop_q;
`else
  assign rdy = !i_rst && (state == IDLE);
`endif

  assign accept = bus.i_val && rdy;

  assign bus.o_rdy   = rdy;
  assign bus.o_dat   = dat_q;
  assign bus.o_val   = val_q;
  assign bus.o_sop   = sop_q;
  assign bus.o_eop   = eop_q;
  assign bus.o_carry = ocarry_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      buf_q    <= '0;
      carry_q  <= '0;
      idx_q    <= '0;
      dat_q    <= '0;
      val_q    <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      ocarry_q <= '0;
`ifdef REDUN_SER_DBUF_EN
      buf2_q   <= '0;
      full2_q  <= 1'b0;
`endif
    end else begin
`ifdef REDUN_SER_DBUF_EN
      if (accept && (state != IDLE) && !handoff) begin
        buf2_q  <= bus.i_dat;
        full2_q <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            buf_q   <= bus.i_dat;
            idx_q   <= '0;
            carry_q <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          dat_q    <= sum_word;
          carry_q  <= sum_carry;
          val_q    <= 1'b1;
          sop_q    <= 1'b1;
          eop_q    <= ONE_ELEMENT;
          ocarry_q <= ONE_ELEMENT ? sum_carry : '0;
          idx_q    <= IDX_W'(1);
          buf_q    <= buf_q >> DSP_BIT_LEN;
          state    <= STREAM;
        end
        STREAM: begin
          if (bus.i_rdy) begin
            if (eop_q) begin
              val_q    <= 1'b0;
              sop_q    <= 1'b0;
              eop_q    <= 1'b0;
              ocarry_q <= '0;
              idx_q    <= '0;
              carry_q  <= '0;
`ifdef REDUN_SER_DBUF_EN
              // The queued vector always goes first; a fresh one is taken directly only when the queue is empty.
              if (full2_q) begin
                buf_q   <= buf2_q;
                full2_q <= 1'b0;
                state   <= LOAD;
              end else if (accept) begin
                buf_q <= bus.i_dat;
                state <= LOAD;
              end else begin
                state <= IDLE;
              end
`else
              state <= IDLE;
`endif
            end else if (idx_q < NUM_IDX) begin
              dat_q    <= sum_word;
              carry_q  <= sum_carry;
              sop_q    <= 1'b0;
              eop_q    <= (idx_q == LAST_IDX);
              ocarry_q <= (idx_q == LAST_IDX) ? sum_carry : '0;
              idx_q    <= idx_q + IDX_W'(1);
              buf_q    <= buf_q >> DSP_BIT_LEN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
